// File: rtl/gray_fifo_pkg.sv
// gray_fifo shared definitions
// defaults and Gray conversion helpers
package gray_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_fifo_ptr.sv
// gray_ptr: binary pointer with registered Gray mirror
// next-state values exported for registered flag logic
module gray_ptr
  import gray_fifo_pkg::*;
#(
  parameter int W = DEF_ADDR_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next
);

  logic [W-1:0] gray;

  assign bin_next  = bin + W'(inc);
  assign gray_next = inc ? W'(bin2gray(32'(bin_next))) : gray;

  // pointer pair advances together on inc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/gray_fifo.sv
// gray_fifo: single-clock FIFO, Gray pointers
// registered exact full/empty/level flags
module gray_fifo
  import gray_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int PW = ADDR_W + 1;
  localparam int N  = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [N];

  logic          wr_acc;
  logic          rd_acc;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rd_gray_next;
  logic          empty_next;
  logic          full_next;
  logic [PW-1:0] level_next;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  gray_ptr #(.W(PW)) u_wr_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (wr_acc),
    .bin       (wr_bin),
    .bin_next  (wr_bin_next),
    .gray_next (wr_gray_next)
  );

  gray_ptr #(.W(PW)) u_rd_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (rd_acc),
    .bin       (rd_bin),
    .bin_next  (rd_bin_next),
    .gray_next (rd_gray_next)
  );

  // flags from next-state Gray pointers
  always_comb begin
    empty_next = (wr_gray_next == rd_gray_next);
    full_next  = (wr_gray_next ==
                  {~rd_gray_next[ADDR_W:ADDR_W-1],
                   rd_gray_next[ADDR_W-2:0]});
    level_next = wr_bin_next - rd_bin_next;
  end

  // register flags, level and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty <= 1'b1;
      full  <= 1'b0;
      level <= '0;
      dout  <= '0;
    end else begin
      empty <= empty_next;
      full  <= full_next;
      level <= level_next;
      if (rd_acc) begin
        dout <= mem[rd_bin[ADDR_W-1:0]];
      end
    end
  end

  // storage array, contents not reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_bin[ADDR_W-1:0]] <= din;
    end
  end

endmodule

// File: tb/tb_gray_fifo.sv
// tb_gray_fifo: directed stimulus with scoreboard queue
// reference occupancy model drives flag expectations
module tb_gray_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [AW:0]   level;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [$];
  int            m_lvl = 0;
  logic [DW-1:0] m_dout = '0;

  gray_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_dout"}, int'(dout), int'(m_dout));
    chk({tag, "_level"}, int'(level), m_lvl);
    chk({tag, "_full"}, int'(full), int'(m_lvl == D));
    chk({tag, "_empty"}, int'(empty), int'(m_lvl == 0));
  endtask

  task automatic step(input logic w, input logic r,
                      input logic [DW-1:0] d, input string tag);
    logic wa;
    logic ra;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    wa = w && (m_lvl < D);
    ra = r && (m_lvl > 0);
    if (ra) begin
      m_dout = sb.pop_front();
      m_lvl--;
    end
    if (wa) begin
      sb.push_back(d);
      m_lvl++;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_state(tag);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("reset");

    // read while empty
    step(1'b0, 1'b1, 8'h00, "rd_empty0");
    step(1'b0, 1'b1, 8'h00, "rd_empty1");

    // write 1..10, idle, read 10
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 8'(i), "wr10");
    step(1'b0, 1'b0, 8'h00, "idle");
    step(1'b0, 1'b0, 8'h00, "idle");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "rd10");

    // fill to full, overflow write, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "fill");
    step(1'b1, 1'b0, 8'hAA, "overflow");
    step(1'b0, 1'b1, 8'h00, "first_rd");
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 8'h00, "drain");

    // wrap through half-full FIFO
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "half");
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h48 + i), "wrap");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "wrap_dr");

    // simultaneous at level 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h80 + i), "to5");
    step(1'b1, 1'b1, 8'hC5, "sim5");
    // simultaneous when full
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(8'h90 + i), "to16");
    step(1'b1, 1'b1, 8'hEE, "sim_full");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, "dr15");
    // simultaneous when empty
    step(1'b1, 1'b1, 8'h5A, "sim_empty");
    step(1'b0, 1'b1, 8'h00, "sim_empty_rd");

    // async reset mid-stream at level 7
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), "to7");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_lvl  = 0;
    m_dout = '0;
    chk_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h3C, "post_rst_wr");
    step(1'b0, 1'b1, 8'h00, "post_rst_rd");
    chk("post_rst_data", int'(dout), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
